// File: rtl/branch_resolve_if.sv
// Fetch/execute redirect bus between the execute-stage branch resolver and fetch.
interface branch_resolve_if;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_ir;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        d_valid;
  logic [31:0] d_npc;
  logic        branch_sig;
  logic [31:0] branch_pc;
  logic [31:0] branch_plus4;
  logic        branch;
  logic        success;
  logic        failure;
  logic        flushD;
  logic        flushE;

  modport master (
    output ex_valid, ex_stall, ex_pc, ex_ir, ex_rs1_data, ex_rs2_data, ex_imm,
    output d_valid, d_npc,
    input  branch_sig, branch_pc, branch_plus4, branch, success, failure, flushD, flushE
  );

  modport slave (
    input  ex_valid, ex_stall, ex_pc, ex_ir, ex_rs1_data, ex_rs2_data, ex_imm,
    input  d_valid, d_npc,
    output branch_sig, branch_pc, branch_plus4, branch, success, failure, flushD, flushE
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with mispredict flush FSM.
// Optional BRANCH_STATS_EN adds branch / mispredict counters.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolve_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_b, is_jal, is_jalr, is_ctl;
  logic        taken;
  logic [31:0] target, plus4, actual;
  logic        accept, hit;

  always_comb begin
    opcode  = bus.ex_ir[6:0];
    funct3  = bus.ex_ir[14:12];
    is_b    = (opcode == 7'b1100011);
    is_jal  = (opcode == 7'b1101111);
    is_jalr = (opcode == 7'b1100111);
    is_ctl  = is_b | is_jal | is_jalr;

    taken = 1'b0;
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end else if (is_b) begin
      case (funct3)
        3'b000:  taken = (bus.ex_rs1_data == bus.ex_rs2_data);
        3'b001:  taken = (bus.ex_rs1_data != bus.ex_rs2_data);
        3'b100:  taken = ($signed(bus.ex_rs1_data) <  $signed(bus.ex_rs2_data));
        3'b101:  taken = ($signed(bus.ex_rs1_data) >= $signed(bus.ex_rs2_data));
        3'b110:  taken = (bus.ex_rs1_data <  bus.ex_rs2_data);
        3'b111:  taken = (bus.ex_rs1_data >= bus.ex_rs2_data);
        default: taken = 1'b0;
      endcase
    end

    if (is_jalr) target = (bus.ex_rs1_data + bus.ex_imm) & ~32'h1;
    else         target = bus.ex_pc + bus.ex_imm;
    plus4  = bus.ex_pc + 32'd4;
    actual = taken ? target : plus4;

    accept = (state == RUN) && bus.ex_valid && !bus.ex_stall && is_ctl;
    // A bubble in decode means there is no prediction to trust: force a redirect.
    hit    = bus.d_valid && (bus.d_npc == actual);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (accept && !hit) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt <= 2'd1) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.branch_sig   <= 1'b0;
      bus.branch       <= 1'b0;
      bus.success      <= 1'b0;
      bus.failure      <= 1'b0;
      bus.branch_pc    <= '0;
      bus.branch_plus4 <= '0;
      bus.flushD       <= 1'b0;
      bus.flushE       <= 1'b0;
    end else begin
      bus.branch_sig <= accept && taken;
      bus.branch     <= accept && taken;
      bus.success    <= accept && hit;
      bus.failure    <= accept && !hit;
      if (accept) begin
        bus.branch_pc    <= target;
        bus.branch_plus4 <= plus4;
      end
      // Flush flags track the registered state so they cover exactly the FLUSH cycles.
      bus.flushD <= (state_next == FLUSH);
      bus.flushE <= (state_next == FLUSH);
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      stat_branches <= stat_branches + 32'd1;
      if (!hit) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  branch_resolve_if bif();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] BX10 = 32'h00002063;
  localparam logic [31:0] BLT  = 32'h00004063;
  localparam logic [31:0] BGE  = 32'h00005063;
  localparam logic [31:0] BLTU = 32'h00006063;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] JALR = 32'h00000067;
  localparam logic [31:0] ADDI = 32'h00000013;

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic dv,
                       input logic [31:0] npc);
    bif.ex_valid = 1'b1; bif.ex_stall = 1'b0; bif.ex_ir = ir; bif.ex_pc = pc;
    bif.ex_rs1_data = rs1; bif.ex_rs2_data = rs2; bif.ex_imm = imm;
    bif.d_valid = dv; bif.d_npc = npc;
  endtask

  task automatic idle();
    bif.ex_valid = 1'b0; bif.ex_stall = 1'b0; bif.ex_ir = '0; bif.d_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    bif.ex_pc = '0; bif.ex_rs1_data = '0; bif.ex_rs2_data = '0; bif.ex_imm = '0; bif.d_npc = '0;
    step(); step();
    tests++; if ({bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD, bif.flushE} !== 6'b0) begin fails++;
      $display("FAIL reset_flags got %b exp 000000", {bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD, bif.flushE}); end
    tests++; if (bif.branch_pc !== 32'h0) begin fails++; $display("FAIL reset_branch_pc got %h exp 0", bif.branch_pc); end
    tests++; if (bif.branch_plus4 !== 32'h0) begin fails++; $display("FAIL reset_branch_plus4 got %h exp 0", bif.branch_plus4); end
`ifdef BRANCH_STATS_EN
    tests++; if ({stat_branches, stat_mispredicts} !== 64'h0) begin fails++;
      $display("FAIL reset_stats got %h/%h exp 0/0", stat_branches, stat_mispredicts); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_beq_hit();
    issue(BEQ, 32'h8000, 32'd5, 32'd5, 32'h10, 1'b1, 32'h8010);
    step(); idle();
    tests++; if ({bif.success, bif.branch_sig, bif.branch, bif.failure, bif.flushD} !== 5'b11100) begin fails++;
      $display("FAIL beq_flags got %b exp 11100", {bif.success, bif.branch_sig, bif.branch, bif.failure, bif.flushD}); end
    tests++; if (bif.branch_pc !== 32'h8010) begin fails++; $display("FAIL beq_branch_pc got %h exp 00008010", bif.branch_pc); end
    step();
    tests++; if ({bif.success, bif.branch} !== 2'b00) begin fails++; $display("FAIL beq_pulse_end got %b exp 00", {bif.success, bif.branch}); end
    tests++; if (bif.branch_pc !== 32'h8010) begin fails++; $display("FAIL beq_pc_hold got %h exp 00008010", bif.branch_pc); end
  endtask

  task automatic test_blt_mispredict();
    issue(BLT, 32'h8004, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b1, 32'h8008);
    step();
    // A perfectly predicted JAL is offered throughout the flush; it must be ignored until RUN.
    issue(JAL, 32'h8100, 32'h0, 32'h0, 32'h40, 1'b1, 32'h8140);
    tests++; if ({bif.failure, bif.success, bif.branch_sig, bif.flushD, bif.flushE} !== 5'b10111) begin fails++;
      $display("FAIL blt_flags got %b exp 10111", {bif.failure, bif.success, bif.branch_sig, bif.flushD, bif.flushE}); end
    tests++; if (bif.branch_pc !== 32'h8024) begin fails++; $display("FAIL blt_branch_pc got %h exp 00008024", bif.branch_pc); end
    step();
    tests++; if ({bif.flushD, bif.flushE, bif.branch, bif.success, bif.failure} !== 5'b11000) begin fails++;
      $display("FAIL blt_flush2 got %b exp 11000", {bif.flushD, bif.flushE, bif.branch, bif.success, bif.failure}); end
    step();
    tests++; if ({bif.flushD, bif.flushE, bif.branch, bif.success} !== 4'b0000) begin fails++;
      $display("FAIL blt_flush_end got %b exp 0000", {bif.flushD, bif.flushE, bif.branch, bif.success}); end
    step(); idle();
    tests++; if ({bif.branch, bif.success} !== 2'b11) begin fails++; $display("FAIL blt_first_accept got %b exp 11", {bif.branch, bif.success}); end
    tests++; if (bif.branch_pc !== 32'h8140) begin fails++; $display("FAIL blt_jal_pc got %h exp 00008140", bif.branch_pc); end
    step();
  endtask

  task automatic test_bltu_not_taken();
    issue(BLTU, 32'h8004, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b1, 32'h8024);
    step(); idle();
    tests++; if ({bif.failure, bif.branch_sig, bif.branch, bif.success} !== 4'b1000) begin fails++;
      $display("FAIL bltu_flags got %b exp 1000", {bif.failure, bif.branch_sig, bif.branch, bif.success}); end
    tests++; if (bif.branch_plus4 !== 32'h8008) begin fails++; $display("FAIL bltu_plus4 got %h exp 00008008", bif.branch_plus4); end
    step(); step();
    tests++; if (bif.flushD !== 1'b0) begin fails++; $display("FAIL bltu_flush_end got %b exp 0", bif.flushD); end
  endtask

  task automatic test_jalr();
    issue(JALR, 32'h8200, 32'h9001, 32'h0, 32'h2, 1'b1, 32'h9002);
    step(); idle();
    tests++; if ({bif.success, bif.failure, bif.branch_sig} !== 3'b101) begin fails++;
      $display("FAIL jalr_flags got %b exp 101", {bif.success, bif.failure, bif.branch_sig}); end
    tests++; if (bif.branch_pc !== 32'h9002) begin fails++; $display("FAIL jalr_branch_pc got %h exp 00009002", bif.branch_pc); end
    tests++; if (bif.branch_plus4 !== 32'h8204) begin fails++; $display("FAIL jalr_plus4 got %h exp 00008204", bif.branch_plus4); end
    step();
    issue(JALR, 32'h8200, 32'h9001, 32'h0, 32'h2, 1'b0, 32'h9002);
    step(); idle();
    tests++; if ({bif.success, bif.failure, bif.flushD} !== 3'b011) begin fails++;
      $display("FAIL jalr_dvalid0 got %b exp 011", {bif.success, bif.failure, bif.flushD}); end
    step(); step();
  endtask

  task automatic test_wrap_and_misc();
    issue(BGE, 32'hFFFFFFF0, 32'd1, 32'hFFFFFFFF, 32'h20, 1'b1, 32'h10);
    step(); idle();
    tests++; if ({bif.success, bif.branch_sig} !== 2'b11) begin fails++; $display("FAIL bge_flags got %b exp 11", {bif.success, bif.branch_sig}); end
    tests++; if (bif.branch_pc !== 32'h10) begin fails++; $display("FAIL bge_wrap_pc got %h exp 00000010", bif.branch_pc); end
    tests++; if (bif.branch_plus4 !== 32'hFFFFFFF4) begin fails++; $display("FAIL bge_plus4 got %h exp fffffff4", bif.branch_plus4); end
    issue(BX10, 32'h8500, 32'd7, 32'd7, 32'h40, 1'b1, 32'h8504);
    step(); idle();
    tests++; if ({bif.success, bif.branch_sig, bif.failure} !== 3'b100) begin fails++;
      $display("FAIL f3_010 got %b exp 100", {bif.success, bif.branch_sig, bif.failure}); end
    issue(ADDI, 32'h8600, 32'd1, 32'd1, 32'h40, 1'b1, 32'h1234);
    step(); idle();
    tests++; if ({bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD} !== 5'b0) begin fails++;
      $display("FAIL addi_ignored got %b exp 00000", {bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD}); end
    tests++; if (bif.branch_plus4 !== 32'h8504) begin fails++; $display("FAIL addi_plus4_hold got %h exp 00008504", bif.branch_plus4); end
  endtask

  task automatic test_stall();
    issue(JAL, 32'h8300, 32'h0, 32'h0, 32'h100, 1'b1, 32'h8400);
    bif.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({bif.branch, bif.success, bif.failure} !== 3'b000) begin fails++;
        $display("FAIL stall_cycle%0d got %b exp 000", i, {bif.branch, bif.success, bif.failure}); end
    end
    bif.ex_stall = 1'b0;
    step(); idle();
    tests++; if ({bif.branch, bif.success, bif.failure} !== 3'b110) begin fails++;
      $display("FAIL stall_release got %b exp 110", {bif.branch, bif.success, bif.failure}); end
    tests++; if (bif.branch_pc !== 32'h8400) begin fails++; $display("FAIL stall_pc got %h exp 00008400", bif.branch_pc); end
    step();
    tests++; if (bif.branch !== 1'b0) begin fails++; $display("FAIL stall_single_pulse got %b exp 0", bif.branch); end
  endtask

  task automatic test_reset_in_flush();
    reset = 1'b1; step(); reset = 1'b0;
`ifdef BRANCH_STATS_EN
    tests++; if ({stat_branches, stat_mispredicts} !== 64'h0) begin fails++;
      $display("FAIL stats_after_reset got %h/%h exp 0/0", stat_branches, stat_mispredicts); end
`endif
    issue(JAL, 32'h8700, 32'h0, 32'h0, 32'h8, 1'b1, 32'h8704);
    step(); idle();
    tests++; if ({bif.failure, bif.flushD} !== 2'b11) begin fails++; $display("FAIL rif_failure got %b exp 11", {bif.failure, bif.flushD}); end
`ifdef BRANCH_STATS_EN
    tests++; if ({stat_branches, stat_mispredicts} !== {32'd1, 32'd1}) begin fails++;
      $display("FAIL stats_one_fail got %h/%h exp 1/1", stat_branches, stat_mispredicts); end
`endif
    step();
    reset = 1'b1;
    step();
    tests++; if ({bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD, bif.flushE} !== 6'b0) begin fails++;
      $display("FAIL rif_outputs got %b exp 000000", {bif.branch_sig, bif.branch, bif.success, bif.failure, bif.flushD, bif.flushE}); end
    tests++; if (bif.branch_pc !== 32'h0) begin fails++; $display("FAIL rif_branch_pc got %h exp 0", bif.branch_pc); end
    reset = 1'b0;
    issue(JAL, 32'h8800, 32'h0, 32'h0, 32'h8, 1'b1, 32'h8808);
    step(); idle();
    tests++; if ({bif.success, bif.branch} !== 2'b11) begin fails++; $display("FAIL rif_run_after got %b exp 11", {bif.success, bif.branch}); end
`ifdef BRANCH_STATS_EN
    tests++; if ({stat_branches, stat_mispredicts} !== {32'd1, 32'd0}) begin fails++;
      $display("FAIL stats_one_hit got %h/%h exp 1/0", stat_branches, stat_mispredicts); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_beq_hit();
    test_blt_mispredict();
    test_bltu_not_taken();
    test_jalr();
    test_wrap_and_misc();
    test_stall();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
